fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline: owns the PC and the IF/ID pipeline register.
//   Drives pc/memread to the instruction memory and captures the returned word (combinational
//   read, word index pc[31:2]) together with PC+4 into IF/ID for the decode stage.
//   Handles hazard-unit stalls, branch/jump redirects (with IF/ID flush) and a halt state.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   IMEM_WORDS 128            instruction memory depth in words; fetch range is [0, IMEM_WORDS*4)
// PORTS
//   clk            in   1   clock, all state updates on rising edge
//   rst_n          in   1   asynchronous active-low reset
//   stall          in   1   hazard unit: hold PC and IF/ID this cycle
//   redirect_valid in   1   EX/ID resolved taken branch or jump
//   redirect_pc    in   32  new fetch address; bits [1:0] are forced to 0
//   halt_req       in   1   stop fetching (terminal instruction decoded)
//   im_ir          in   32  instruction word from instruction memory
//   im_pc          out  32  fetch address to instruction memory (= PC register)
//   im_memread     out  1   instruction memory read enable
//   ifid_ir        out  32  IF/ID instruction (32'h0 = NOP bubble)
//   ifid_pc4       out  32  IF/ID PC+4 of the captured instruction
//   ifid_valid     out  1   IF/ID holds a real instruction
//   fetch_fault    out  1   sticky: a fetch was attempted outside [0, IMEM_WORDS*4)
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_PC, state=BOOT, ifid_ir=0, ifid_pc4=0, ifid_valid=0,
//     fetch_fault=0; im_memread=0. Reset mid-operation discards everything in flight.
//   States: BOOT -> RUN unconditionally after one clock (no fetch in BOOT, memread=0).
//     RUN -> HALT when halt_req=1 and redirect_valid=0. HALT -> RUN only on redirect_valid=1.
//   im_pc = pc (combinational). im_memread = (state==RUN) & ~stall & ~fault_addr,
//     where fault_addr = (pc >= IMEM_WORDS*4).
//   Per-edge priority in RUN: redirect_valid > stall > normal.
//     redirect: pc<=redirect_pc&~3; IF/ID <= bubble (ir=0, pc4=0, valid=0). Wins over stall.
//     stall:    pc and IF/ID all hold their values.
//     normal:   pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); ifid_ir<=im_ir;
//               ifid_pc4<=pc+4; ifid_valid<=1.
//     fault_addr in normal case: pc holds, IF/ID <= bubble, fetch_fault<=1 (sticky to reset).
//   Latency: instruction at pc fetched in cycle N is visible on ifid_* after edge ending N.
//   BOOT/HALT: pc holds (except redirect in HALT), IF/ID <= bubble every edge, stall ignored.
//   halt_req and redirect_valid together: redirect taken, stay in RUN.
//   halt_req with stall: still enters HALT; IF/ID becomes bubble.
//   ifid_ir is never X: bubbles are exactly 32'h0 (sll r0,r0,0).
// TESTING
//   1 Reset then free run, IM loaded 00222820,20610006,00823022,AC640004 -> ifid_ir
//     shows them on edges 2..5 after reset release, ifid_pc4 = 4,8,12,16, valid=1.
//   2 Assert stall for 2 cycles while pc=8 -> pc stays 8, ifid_ir stays 20610006,
//     memread=0 for those cycles; resume fetches 00823022 next.
//   3 redirect_valid with redirect_pc=32'h0000_0006 at pc=12 -> pc becomes 4,
//     ifid_valid=0 / ifid_ir=0 one cycle, then 20610006 with pc4=8.
//   4 stall and redirect_valid same cycle, redirect_pc=0 -> redirect wins, pc=0, bubble.
//   5 Run past IMEM_WORDS=128 (pc=512) -> fetch_fault=1, pc holds 512, bubbles;
//     redirect to 0 resumes fetch, fetch_fault stays 1 until rst_n=0.
//   6 halt_req at pc=8 -> HALT, bubbles, pc fixed 8; rst_n pulsed low mid-halt ->
//     all outputs at reset values immediately, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program
//   counter and the IF/ID pipeline register.
//
//   Each cycle the PC is presented to a combinational instruction memory. The
//   returned word is captured into IF/ID together with PC+4. The stage also
//   handles hazard stalls, branch/jump redirects (which flush IF/ID), a halt
//   state, and a sticky out-of-range fetch fault.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   IMEM_WORDS  instruction memory depth in words; legal fetch range is
//               [0, IMEM_WORDS*4)
//
// Ports
//   clk            clock; all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   stall          hazard unit: hold PC and IF/ID this cycle
//   redirect_valid taken branch/jump resolved downstream
//   redirect_pc    new fetch address (bits [1:0] ignored)
//   halt_req       stop fetching (terminal instruction decoded)
//   im_ir          instruction word returned by instruction memory
//   im_pc          fetch address to instruction memory (the PC register)
//   im_memread     instruction memory read enable
//   ifid_ir        IF/ID instruction (32'h0 is the NOP bubble)
//   ifid_pc4       IF/ID PC+4 of the captured instruction
//   ifid_valid     IF/ID holds a real instruction
//   fetch_fault    sticky: a fetch was attempted outside the legal range
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic [31:0] im_ir,
  output logic [31:0] im_pc,
  output logic        im_memread,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // One extra bit so IMEM_WORDS*4 == 2^32 still compares correctly.
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] ir_p1, ir_nxt;
  logic [31:0] pc4_p1, pc4_nxt;
  logic        vld_p1, vld_nxt;
  logic        fault_q, fault_nxt;
  logic [31:0] pc_plus4;
  logic        fault_addr;

  assign pc_plus4   = pc_p0 + 32'd4;
  assign fault_addr = ({1'b0, pc_p0} >= IMEM_BYTES);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (halt_req && !redirect_valid) state_nxt = HALT;
      HALT:    if (redirect_valid) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Output / datapath-control logic. Default is "PC holds, IF/ID gets a
  // bubble", which covers BOOT, HALT without redirect, halt entry and the
  // out-of-range fetch case.
  always_comb begin
    im_memread = 1'b0;
    pc_nxt     = pc_p0;
    ir_nxt     = 32'h0;
    pc4_nxt    = 32'h0;
    vld_nxt    = 1'b0;
    fault_nxt  = fault_q;
    case (state)
      RUN: begin
        im_memread = ~stall & ~fault_addr;
        if (redirect_valid) begin
          pc_nxt = word_align(redirect_pc);
        end else if (halt_req) begin
          // Entering HALT: PC freezes, IF/ID flushed even under stall.
          pc_nxt = pc_p0;
        end else if (stall) begin
          ir_nxt  = ir_p1;
          pc4_nxt = pc4_p1;
          vld_nxt = vld_p1;
        end else if (fault_addr) begin
          fault_nxt = 1'b1;
        end else begin
          pc_nxt  = pc_plus4;
          ir_nxt  = im_ir;
          pc4_nxt = pc_plus4;
          vld_nxt = 1'b1;
        end
      end
      HALT: begin
        if (redirect_valid) pc_nxt = word_align(redirect_pc);
      end
      default: begin
        pc_nxt = pc_p0;
      end
    endcase
  end

  // PC (p0) -> IF/ID (p1) boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0   <= RESET_PC;
      ir_p1   <= 32'h0;
      pc4_p1  <= 32'h0;
      vld_p1  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_p0   <= pc_nxt;
      ir_p1   <= ir_nxt;
      pc4_p1  <= pc4_nxt;
      vld_p1  <= vld_nxt;
      fault_q <= fault_nxt;
    end
  end

  assign im_pc       = pc_p0;
  assign ifid_ir     = ir_p1;
  assign ifid_pc4    = pc4_p1;
  assign ifid_valid  = vld_p1;
  assign fetch_fault = fault_q;

endmodule
